tf_addr_gen: RTL and testbench

Twiddle-factor address scheduler for the two-butterfly NTT core. On a start pulse it walks every stage of an N-point NTT (Cooley-Tukey) or INTT (Gentleman-Sande) and issues, once per cycle, the twiddle ROM addresses for the two butterflies processed in parallel. It also issues the bank-select (`special_add`) and `op` controls consumed by the twiddle ROM wrapper. It sits between the top-level NTT controller and the twiddle ROM, in lockstep with the data-memory address generator.

---
 rtl/tf_addr_gen.sv | 156 +++++++++++++++
 tb/tb_tf_addr_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tf_addr_gen.sv
// tf_addr_gen: twiddle ROM address scheduler for the two-butterfly NTT/INTT core.
// Define TF_DOUT_VALID_EN to add tf_dvalid and delay done to line up with ROM data.
module tf_addr_gen #(
    parameter int LOGN      = 8,
    parameter int ADDR_W    = 11,
    parameter int INTT_BASE = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              mode,
    input  logic              hold,
    output logic              op,
    output logic [ADDR_W-1:0] gamma1_add,
    output logic [ADDR_W-1:0] gamma2_add,
    output logic              special_add,
    output logic              tf_valid,
    output logic [3:0]        stage,
    output logic              busy,
`ifdef TF_DOUT_VALID_EN
    output logic              tf_dvalid,
`endif
    output logic              done
);
    localparam int         JW     = LOGN - 2;
    localparam logic [3:0] S_LAST = 4'(LOGN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [JW-1:0]       j_q, j_d;
    logic [3:0]          s_q, s_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   g1_q, g1_d, g2_q, g2_d;
    logic                sp_q, sp_d;
    logic                val_q, val_d;
    logic [3:0]          stage_q, stage_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   base, pow, grp0, grp1;
    logic [3:0]          sh;
    logic                last_j, last_s;

    // Group index of butterfly b is b >> (LOGN-1-s); the pair is b0=2j, b1=2j+1.
    assign base   = op_q ? ADDR_W'(INTT_BASE) : '0;
    assign sh     = S_LAST - s_q;
    assign pow    = ADDR_W'(1) << s_q;
    assign grp0   = ADDR_W'({j_q, 1'b0}) >> sh;
    assign grp1   = ADDR_W'({j_q, 1'b1}) >> sh;
    assign last_j = &j_q;
    assign last_s = op_q ? (s_q == 4'd0) : (s_q == S_LAST);

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        s_d     = s_q;
        op_d    = op_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        sp_d    = sp_q;
        val_d   = 1'b0;
        stage_d = stage_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = '0;
                    s_d     = mode ? S_LAST : 4'd0;
                    op_d    = mode;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (!hold) begin
                    g1_d    = base + pow + grp0;
                    g2_d    = base + pow + grp1;
                    sp_d    = (s_q == S_LAST);
                    val_d   = 1'b1;
                    stage_d = s_q;
                    j_d     = j_q + JW'(1);
                    if (last_j) begin
                        state_d = last_s ? DONE : RUN;
                        s_d     = last_s ? s_q : (op_q ? s_q - 4'd1 : s_q + 4'd1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            j_q     <= '0;
            s_q     <= '0;
            op_q    <= 1'b0;
            g1_q    <= '0;
            g2_q    <= '0;
            sp_q    <= 1'b0;
            val_q   <= 1'b0;
            stage_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            s_q     <= s_d;
            op_q    <= op_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            sp_q    <= sp_d;
            val_q   <= val_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign op          = op_q;
    assign gamma1_add  = g1_q;
    assign gamma2_add  = g2_q;
    assign special_add = sp_q;
    assign tf_valid    = val_q;
    assign stage       = stage_q;
    assign busy        = busy_q;

`ifdef TF_DOUT_VALID_EN
    logic dv_q, dv_d, dd_q, dd_d;

    // Both flags trail by one cycle so they line up with the ROM read data.
    assign dv_d = val_q;
    assign dd_d = done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_q <= 1'b0;
            dd_q <= 1'b0;
        end else begin
            dv_q <= dv_d;
            dd_q <= dd_d;
        end
    end

    assign tf_dvalid = dv_q;
    assign done      = dd_q;
`else
    assign done = done_q;
`endif
endmodule

// File: tb/tb_tf_addr_gen.sv
// tb_tf_addr_gen: directed table-driven bench for tf_addr_gen (default build).
module tb_tf_addr_gen;
    localparam int LOGN = 8, ADDR_W = 11, INTT_BASE = 1024;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, mode = 1'b0, hold = 1'b0;
    logic op, special_add, tf_valid, busy, done;
    logic [ADDR_W-1:0] gamma1_add, gamma2_add;
    logic [3:0] stage;

    tf_addr_gen #(.LOGN(LOGN), .ADDR_W(ADDR_W), .INTT_BASE(INTT_BASE)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .hold(hold),
        .op(op), .gamma1_add(gamma1_add), .gamma2_add(gamma2_add),
        .special_add(special_add), .tf_valid(tf_valid), .stage(stage),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cg1[2][512], cg2[2][512], csp[2][512], cst[2][512], cop[2][512];

    typedef struct {int m; int idx; int g1; int g2; int sp; int st;} vec_t;
    vec_t vecs[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Start a transform, capture every valid pair, optionally stall 3 cycles after pair hold_at-1.
    task automatic run_cap(input int m, input int hold_at, input int hold_g, input int hold_st,
                           output int nv, output int done_cyc);
        int hleft;
        hleft = 0;
        nv = 0;
        done_cyc = 0;
        @(negedge clk);
        mode = m[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 1000 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_rise", busy, 1);
            if (hleft > 0) begin
                chk("hold_valid", tf_valid, 0);
                chk("hold_g1", gamma1_add, hold_g);
                chk("hold_g2", gamma2_add, hold_g);
                chk("hold_stage", stage, hold_st);
                hleft--;
                if (hleft == 0) hold = 1'b0;
            end else if (tf_valid) begin
                if (nv < 512) begin
                    cg1[m][nv] = int'(gamma1_add);
                    cg2[m][nv] = int'(gamma2_add);
                    csp[m][nv] = int'(special_add);
                    cst[m][nv] = int'(stage);
                    cop[m][nv] = int'(op);
                end
                nv++;
                if (nv == hold_at) begin
                    hold = 1'b1;
                    hleft = 3;
                end
            end
            if (done) begin
                done_cyc = c;
                chk("busy_at_done", busy, 0);
            end
        end
        if (done_cyc == 0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int nv, dc, nvs;
        vecs = '{
            '{0,   0,    1,    1, 0, 0}, '{0,  63,    1,    1, 0, 0},
            '{0,  64,    2,    2, 0, 1}, '{0,  95,    2,    2, 0, 1},
            '{0,  96,    3,    3, 0, 1}, '{0, 127,    3,    3, 0, 1},
            '{0, 128,    4,    4, 0, 2}, '{0, 232,   13,   13, 0, 3},
            '{0, 394,   74,   74, 0, 6}, '{0, 448,  128,  129, 1, 7},
            '{0, 470,  172,  173, 1, 7}, '{0, 511,  254,  255, 1, 7},
            '{1,   0, 1152, 1153, 1, 7}, '{1,  63, 1278, 1279, 1, 7},
            '{1,  64, 1088, 1088, 0, 6}, '{1, 128, 1056, 1056, 0, 5},
            '{1, 191, 1087, 1087, 0, 5}, '{1, 448, 1025, 1025, 0, 0},
            '{1, 511, 1025, 1025, 0, 0}
        };
        repeat (2) @(negedge clk);
        chk("rst_g1", gamma1_add, 0);
        chk("rst_g2", gamma2_add, 0);
        chk("rst_valid", tf_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_op", op, 0);
        chk("rst_sp", special_add, 0);
        chk("rst_stage", stage, 0);
        rstn = 1'b1;

        run_cap(0, 0, 0, 0, nv, dc);
        chk("ntt_count", nv, 512);
        chk("ntt_done_cyc", dc, 513);
        chk("ntt_op", cop[0][0], 0);
        run_cap(1, 0, 0, 0, nv, dc);
        chk("intt_count", nv, 512);
        chk("intt_done_cyc", dc, 513);
        chk("intt_op", cop[1][0], 1);
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("v%0d_g1", i), cg1[vecs[i].m][vecs[i].idx], vecs[i].g1);
            chk($sformatf("v%0d_g2", i), cg2[vecs[i].m][vecs[i].idx], vecs[i].g2);
            chk($sformatf("v%0d_sp", i), csp[vecs[i].m][vecs[i].idx], vecs[i].sp);
            chk($sformatf("v%0d_st", i), cst[vecs[i].m][vecs[i].idx], vecs[i].st);
        end

        // Stall right after pair j=10 of stage 2 (pair index 138).
        run_cap(0, 139, 4, 2, nv, dc);
        chk("hold_count", nv, 512);
        chk("hold_done_cyc", dc, 516);
        chk("hold_j10", cg1[0][138], 4);
        chk("hold_j15", cg1[0][143], 4);
        chk("hold_j16", cg1[0][144], 5);
        chk("hold_last_g2", cg2[0][511], 255);

        // INTT run with a stray start (mode=0) at cycle 100 and reset at cycle 200.
        @(negedge clk);
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvs = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) chk("mid_no_done", done, 0);
            if (c == 100) begin
                mode = 1'b0;
                start = 1'b1;
            end
            if (c == 101) start = 1'b0;
            if (c == 150) begin
                chk("busy_start_g1", gamma1_add, 1066);
                chk("busy_start_stage", stage, 5);
                chk("busy_start_op", op, 1);
            end
        end
        rstn = 1'b0;
        #1;
        chk("arst_valid", tf_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_g1", gamma1_add, 0);
        chk("arst_g2", gamma2_add, 0);
        chk("arst_sp", special_add, 0);
        chk("arst_stage", stage, 0);
        chk("arst_op", op, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) nvs++;
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) nvs++;
        end
        chk("arst_quiet", nvs, 0);
        run_cap(0, 0, 0, 0, nv, dc);
        chk("fresh_count", nv, 512);
        chk("fresh_done_cyc", dc, 513);
        chk("fresh_first_g1", cg1[0][0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
